// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path: funct3 encodings, LSU state type,
// default data-memory depth and the funct3 legality rule.
package riscv_mem_pkg;

  localparam int unsigned DEFAULT_MEM_DEPTH = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_t;

  // Stores only have signed-agnostic B/H/W; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte/halfword lane handling: load extraction with sign/zero
// extension, and store merge of a sub-word into an existing memory word.
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off[1]) store_word[31:16] = wdata[15:0];
        else             store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage controller: turns byte-addressed loads/stores into word accesses,
// with read-modify-write for sub-word stores and one response per request.
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] MemData_out
);

  lsu_state_t  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] idx_q, idx_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merged_q, merged_d;

  logic [31:0] req_idx;
  logic        req_misaligned;
  logic        req_oob;
  logic        req_err;
  logic [31:0] align_load;
  logic [31:0] align_store;

  lsu_lane_align u_align (
    .funct3    (funct3_q),
    .byte_off  (off_q),
    .word      (MemData_out),
    .wdata     (wdata_q),
    .load_data (align_load),
    .store_word(align_store)
  );

  always_comb begin
    req_idx        = {2'b00, req_addr[31:2]};
    req_misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    req_oob        = (req_idx >= MEM_DEPTH);
    req_err        = req_misaligned || req_oob || !f3_legal(req_write, req_funct3);
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          wdata_d  = req_wdata;
          idx_d    = req_idx;
          err_d    = req_err;
          if (req_err) begin
            rdata_d = '0;
            state_d = RESP;
          end else if (!req_write) begin
            state_d = LOAD;
          end else if (req_funct3 == F3_W) begin
            // Full-word stores skip the read; the merged word is the store data.
            merged_d = req_wdata;
            rdata_d  = '0;
            state_d  = WRITE;
          end else begin
            rdata_d = '0;
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = align_load;
        state_d = RESP;
      end
      RMW_RD: begin
        merged_d = align_store;
        state_d  = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
    end
  end

  // Strobes come straight from the registered state so they are glitch-free
  // and mutually exclusive; ready is also held low while reset is asserted.
  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = rdata_q;
    MemRead    = (state_q == LOAD) || (state_q == RMW_RD);
    MemWrite   = (state_q == WRITE) && write_q;
    mem_addr   = idx_q;
    mem_wdata  = merged_q;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage controller between the execute stage and the 64-word data memory.
- Takes a byte-addressed load/store request from the pipeline and converts it to word-indexed memory accesses.
- Performs byte-lane extraction with sign/zero extension on loads.
- Performs read-modify-write for SB/SH, because the data memory has no byte enables.
- Returns one response per request.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in the data memory. Word index range is 0..MEM_DEPTH-1.
- DATA_W, 32, data width. Fixed at 32; the parameter exists for documentation only.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1=store, 0=load.
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (rs2).
- resp_valid  output  1  one-cycle response pulse.
- resp_err  output  1  qualifies resp_valid; high for misaligned, out-of-range or illegal funct3.
- resp_rdata  output  32  extended load data. 0 for stores and errors.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- mem_addr  output  32  word index = {2'b00, req_addr[31:2]}.
- mem_wdata  output  32  word written to memory.
- MemData_out  input  32  combinational read data from memory. Valid in the same cycle MemRead is high.

Behaviour:
- Reset is asynchronous. State is forced to IDLE and all registers are cleared. Outputs during reset:
  - req_ready=0
  - resp_valid=0, resp_err=0, resp_rdata=0
  - MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0
- After reset deasserts, req_ready=1.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr, wdata and the word index, then compute err. err is set if any of:
    - halfword with addr[0]=1
    - word with addr[1:0]!=0
    - word index >= MEM_DEPTH
    - load funct3 outside {000,001,010,100,101}
    - store funct3 outside {000,001,010}
  - Transitions:
    - err: go to RESP with resp_err=1.
    - load: go to LOAD.
    - SW: go to WRITE with merged word = wdata.
    - SB/SH: go to RMW_RD.
- LOAD:
  - MemRead=1.
  - Select byte lane addr[1:0], or halfword addr[1]. Sign-extend for B/H, zero-extend for BU/HU. Register the result into resp_rdata.
  - Go to RESP.
- RMW_RD:
  - MemRead=1.
  - Merge into MemData_out: SB replaces byte lane addr[1:0] with wdata[7:0]; SH replaces halfword addr[1] with wdata[15:0].
  - Register the merged word, then go to WRITE.
- WRITE:
  - MemWrite=1, mem_wdata=merged word. The memory captures it on the rising edge that ends this state.
  - Go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, req_ready=0.
  - Go to IDLE. The next request is accepted in the following cycle.
- Strobe rules:
  - MemRead and MemWrite are decoded from the registered state only. They are never both high.
  - Each is high for exactly one cycle per access.
  - mem_addr is held stable from LOAD/RMW_RD through WRITE.
- Latency, with the request accepted at edge T:
  - load: resp at cycle T+2
  - SW: resp at T+2
  - SB/SH: resp at T+3
  - error: resp at T+1, with no memory strobe at all.
- Throughput: at most one outstanding request. req_valid while req_ready=0 is ignored; the upstream stage holds it.
- Reset mid-operation: the operation is aborted and no MemWrite is issued afterwards. A partially completed RMW leaves memory unchanged, because the write occurs only in WRITE.
- resp_rdata holds its value until the next LOAD or error overwrites it. It is cleared to 0 on store responses.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding typedef lsu_state_t
  - MEM_DEPTH default
- One natural sub-module: lsu_lane_align, purely combinational. It provides load extraction/extension and store merge from (funct3, addr[1:0], word, wdata). Reused by the bench as a reference model.

Test Plan:
- Memory word 3 = 32'h8765_43A1; LB addr 32'h0000_000C -> resp at T+2, rdata 32'hFFFF_FFA1. LBU same address -> 32'h0000_00A1.
- Same word; LH addr 32'h0000_000E -> rdata 32'hFFFF_8765. LHU -> 32'h0000_8765. LW addr 32'h0000_000C -> 32'h8765_43A1.
- Word 5 = 32'h1122_3344; SB addr 32'h0000_0015, wdata 32'hDEAD_BEEF -> MemRead at T+1, MemWrite at T+2 with mem_wdata 32'h1122_EF44, resp at T+3; subsequent LW returns 32'h1122_EF44.
- SH addr 32'h0000_0001 -> resp_err=1 at T+1, no MemRead/MemWrite. LW addr 32'h0000_0100 (word 64) -> resp_err=1.
- SW addr 32'h0000_0008, wdata 32'hCAFE_F00D -> single MemWrite at T+1, resp at T+2, word 2 = 32'hCAFE_F00D; req_valid held during busy is not double-accepted.
- SB issued; assert reset in RMW_RD -> outputs reset immediately (asynchronous), no MemWrite pulse, target word unchanged; req_ready=1 after release.
